// File: rtl/pipe_intr_irq_ctrl.sv
// Interrupt request controller: synchronizes NSRC sources, keeps per-source
// pending/mask/edge-mode registers, raises intr for the lowest-index
// pending+unmasked source and tracks the inta/eoi handshake.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no request outstanding; waiting for a pending, unmasked source
// ST_REQ     | intr held high with irq_id frozen until inta arrives
// ST_SERVICE | granted; in_service high until eoi
module pipe_intr_irq_ctrl #(
  parameter int NSRC = 8,
  parameter int IDW  = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NSRC-1:0] i_irq_in,
  output logic            o_intr,
  input  logic            i_inta,
  input  logic            i_eoi,
  output logic [IDW-1:0]  o_irq_id,
  output logic            o_in_service,
  input  logic            i_cfg_we,
  input  logic [1:0]      i_cfg_addr,
  input  logic [31:0]     i_cfg_wdata,
  output logic [31:0]     o_cfg_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_intr;
  logic            r_in_service;
  logic [IDW-1:0]  r_irq_id;
  logic [31:0]     r_cfg_rdata;
  logic [NSRC-1:0] r_s1, r_s2, r_s3;
  logic [NSRC-1:0] r_mask, r_edge, r_pend;

  logic [NSRC-1:0] w_wdata_src;
  logic [NSRC-1:0] w_req;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_w1c;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_pend_next;
  logic [IDW-1:0]  w_sel_id;
  logic            w_grant;
  logic [31:0]     w_status;
  logic [31:0]     w_rd_mux;

  assign w_wdata_src = i_cfg_wdata[NSRC-1:0];

  // Upper write-data bits have no register behind them.
  generate
    if (NSRC < 32) begin : g_unused_wdata
      logic w_unused_wdata;
      assign w_unused_wdata = &{1'b0, i_cfg_wdata[31:NSRC]};
    end
  endgenerate

  assign w_req   = r_pend & r_mask;
  assign w_rise  = r_s2 & ~r_s3;
  assign w_grant = (r_state == ST_REQ) && i_inta;
  assign w_w1c   = (i_cfg_we && (i_cfg_addr == 2'd2)) ? w_wdata_src : '0;

  // Lowest-index pending, unmasked source wins.
  always_comb begin
    w_sel_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_req[i]) w_sel_id = IDW'(i);
    end
  end

  // Edge-mode clear sources: the grant of this id, or a software write-one-to-clear.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_clr[i] = (w_grant && (r_irq_id == IDW'(i))) || w_w1c[i];
    end
  end

  // A new edge beats a simultaneous clear; level-mode bits just mirror the synchronized input.
  assign w_pend_next = (r_edge & (w_rise | (r_pend & ~w_clr))) | (~r_edge & r_s2);

  // Synchronizer, edge history, config registers and pending bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_mask <= '0;
      r_edge <= '0;
      r_pend <= '0;
    end else begin
      r_s1   <= i_irq_in;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_pend <= w_pend_next;
      if (i_cfg_we && (i_cfg_addr == 2'd0)) r_mask <= w_wdata_src;
      if (i_cfg_we && (i_cfg_addr == 2'd1)) r_edge <= w_wdata_src;
    end
  end

  // Request/acknowledge/service sequencing with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_intr       <= 1'b0;
      r_irq_id     <= '0;
      r_in_service <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_state  <= ST_REQ;
            r_intr   <= 1'b1;
            r_irq_id <= w_sel_id;
          end
        end
        ST_REQ: begin
          if (i_inta) begin
            r_state      <= ST_SERVICE;
            r_intr       <= 1'b0;
            r_in_service <= 1'b1;
          end
        end
        ST_SERVICE: begin
          if (i_eoi) begin
            r_state      <= ST_IDLE;
            r_in_service <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_intr       <= 1'b0;
          r_in_service <= 1'b0;
        end
      endcase
    end
  end

  // Status word and read mux.
  always_comb begin
    w_status                = '0;
    w_status[9:8]           = r_state;
    w_status[7]             = r_in_service;
    w_status[IDW-1:0]       = r_irq_id;
    w_rd_mux                = '0;
    case (i_cfg_addr)
      2'd0:    w_rd_mux[NSRC-1:0] = r_mask;
      2'd1:    w_rd_mux[NSRC-1:0] = r_edge;
      2'd2:    w_rd_mux[NSRC-1:0] = r_pend;
      default: w_rd_mux           = w_status;
    endcase
  end

  // Read data is registered every cycle for the currently addressed register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_cfg_rdata <= '0;
    else       r_cfg_rdata <= w_rd_mux;
  end

  assign o_intr       = r_intr;
  assign o_irq_id     = r_irq_id;
  assign o_in_service = r_in_service;
  assign o_cfg_rdata  = r_cfg_rdata;

endmodule

// File: tb/tb_pipe_intr_irq_ctrl.sv
// Bench for pipe_intr_irq_ctrl: directed vector table, hand-written corner
// sequences and a randomized run, all also compared every cycle against a
// behavioural model of the controller.
module tb_pipe_intr_irq_ctrl;

  logic        clk;
  logic        t_rst;
  logic [7:0]  t_irq;
  logic        t_inta, t_eoi, t_we;
  logic [1:0]  t_addr;
  logic [31:0] t_wdata;
  logic        o_intr, o_in_service;
  logic [2:0]  o_irq_id;
  logic [31:0] o_cfg_rdata;

  int checks   = 0;
  int failures = 0;

  pipe_intr_irq_ctrl #(.NSRC(8), .IDW(3)) dut (
    .i_clk        (clk),
    .i_rst        (t_rst),
    .i_irq_in     (t_irq),
    .o_intr       (o_intr),
    .i_inta       (t_inta),
    .i_eoi        (t_eoi),
    .o_irq_id     (o_irq_id),
    .o_in_service (o_in_service),
    .i_cfg_we     (t_we),
    .i_cfg_addr   (t_addr),
    .i_cfg_wdata  (t_wdata),
    .o_cfg_rdata  (o_cfg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model. hist[0] is the newest registered sample of irq_in;
  // hist[1] is the value pending logic sees, hist[2] the one before it.
  logic [7:0]  hist [3];
  logic [7:0]  m_mask, m_edge, m_pend;
  int          m_phase;   // 0 idle, 1 requesting, 2 in service (STATUS encoding)
  int          m_id;
  logic [31:0] m_rdata;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {24'd0, m_mask};
      2'd1:    return {24'd0, m_edge};
      2'd2:    return {24'd0, m_pend};
      default: return (32'(m_phase) << 8) | ((m_phase == 2) ? 32'h80 : 32'h0) | 32'(m_id);
    endcase
  endfunction

  task automatic model_step();
    logic [7:0] np;
    logic [7:0] active;
    logic       clr;
    if (t_rst) begin
      for (int i = 0; i < 3; i++) hist[i] = 8'h00;
      m_mask = 0; m_edge = 0; m_pend = 0; m_phase = 0; m_id = 0; m_rdata = 0;
    end else begin
      m_rdata = m_read(t_addr);
      for (int i = 0; i < 8; i++) begin
        if (m_edge[i]) begin
          clr = (m_phase == 1 && t_inta && m_id == i) ||
                (t_we && t_addr == 2'd2 && t_wdata[i]);
          np[i] = (hist[1][i] && !hist[2][i]) || (m_pend[i] && !clr);
        end else begin
          np[i] = hist[1][i];
        end
      end
      active = m_pend & m_mask;
      if (m_phase == 0) begin
        if (active != 0) begin
          m_phase = 1;
          m_id = 0;
          while (!active[m_id]) m_id++;
        end
      end else if (m_phase == 1) begin
        if (t_inta) m_phase = 2;
      end else begin
        if (t_eoi) m_phase = 0;
      end
      if (t_we && t_addr == 2'd0) m_mask = t_wdata[7:0];
      if (t_we && t_addr == 2'd1) m_edge = t_wdata[7:0];
      m_pend  = np;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = t_irq;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("model_intr",  {31'd0, o_intr},       {31'd0, m_phase == 1});
    chk("model_svc",   {31'd0, o_in_service}, {31'd0, m_phase == 2});
    chk("model_id",    {29'd0, o_irq_id},     32'(m_id));
    chk("model_rdata", o_cfg_rdata,           m_rdata);
  endtask

  task automatic quiet();
    t_inta = 0; t_eoi = 0; t_we = 0; t_wdata = 0;
  endtask

  task automatic do_reset();
    quiet();
    t_irq = 0; t_addr = 0; t_rst = 1;
    cyc();
    t_rst = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    t_we = 1; t_addr = a; t_wdata = d;
    cyc();
    t_we = 0; t_wdata = 0;
  endtask

  typedef struct {
    logic        rst;
    logic [7:0]  irq;
    logic        inta, eoi, we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        e_intr;
    logic [2:0]  e_id;
    logic        e_svc;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [7:0] irq, input logic inta,
                              input logic eoi, input logic we, input logic [1:0] addr,
                              input logic [31:0] wdata, input logic e_intr,
                              input logic [2:0] e_id, input logic e_svc,
                              input logic [31:0] e_rdata);
    vec_t v;
    v.rst = rst; v.irq = irq; v.inta = inta; v.eoi = eoi; v.we = we; v.addr = addr;
    v.wdata = wdata; v.e_intr = e_intr; v.e_id = e_id; v.e_svc = e_svc; v.e_rdata = e_rdata;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    //           rst irq    inta eoi we addr wdata   intr id svc rdata
    tbl[0]  = mk(1, 8'h00, 0, 0, 0, 2'd0, 32'h0,  0, 0, 0, 32'h000);
    tbl[1]  = mk(0, 8'h00, 0, 0, 1, 2'd0, 32'hFF, 0, 0, 0, 32'h000);
    tbl[2]  = mk(0, 8'h00, 0, 0, 1, 2'd1, 32'h0,  0, 0, 0, 32'h000);
    tbl[3]  = mk(0, 8'h28, 0, 0, 0, 2'd0, 32'h0,  0, 0, 0, 32'h0FF);
    tbl[4]  = mk(0, 8'h28, 0, 0, 0, 2'd2, 32'h0,  0, 0, 0, 32'h000);
    tbl[5]  = mk(0, 8'h28, 0, 0, 0, 2'd2, 32'h0,  0, 0, 0, 32'h000);
    tbl[6]  = mk(0, 8'h28, 0, 0, 0, 2'd2, 32'h0,  1, 3, 0, 32'h028);
    tbl[7]  = mk(0, 8'h28, 0, 0, 0, 2'd3, 32'h0,  1, 3, 0, 32'h103);
    tbl[8]  = mk(0, 8'h28, 1, 0, 0, 2'd3, 32'h0,  0, 3, 1, 32'h103);
    tbl[9]  = mk(0, 8'h28, 0, 0, 0, 2'd3, 32'h0,  0, 3, 1, 32'h283);
    tbl[10] = mk(0, 8'h28, 1, 0, 0, 2'd3, 32'h0,  0, 3, 1, 32'h283);
    tbl[11] = mk(0, 8'h28, 0, 1, 0, 2'd3, 32'h0,  0, 3, 0, 32'h283);
    tbl[12] = mk(0, 8'h28, 0, 0, 0, 2'd3, 32'h0,  1, 3, 0, 32'h003);
    tbl[13] = mk(0, 8'h28, 0, 1, 0, 2'd3, 32'h0,  1, 3, 0, 32'h103);
    tbl[14] = mk(1, 8'h00, 0, 0, 0, 2'd3, 32'h0,  0, 0, 0, 32'h000);
    tbl[15] = mk(0, 8'h00, 0, 0, 0, 2'd0, 32'h0,  0, 0, 0, 32'h000);
    tbl[16] = mk(0, 8'h00, 0, 0, 0, 2'd1, 32'h0,  0, 0, 0, 32'h000);
    tbl[17] = mk(0, 8'h00, 0, 0, 0, 2'd2, 32'h0,  0, 0, 0, 32'h000);

    t_rst = 1; t_irq = 0; t_addr = 0;
    quiet();
    for (int i = 0; i < 3; i++) hist[i] = 8'h00;
    m_mask = 0; m_edge = 0; m_pend = 0; m_phase = 0; m_id = 0; m_rdata = 0;

    // Reset and priority vectors.
    for (int r = 0; r < 18; r++) begin
      t_rst = tbl[r].rst; t_irq = tbl[r].irq; t_inta = tbl[r].inta; t_eoi = tbl[r].eoi;
      t_we = tbl[r].we; t_addr = tbl[r].addr; t_wdata = tbl[r].wdata;
      cyc();
      chk($sformatf("vec%0d_intr", r),  {31'd0, o_intr},       {31'd0, tbl[r].e_intr});
      chk($sformatf("vec%0d_id", r),    {29'd0, o_irq_id},     {29'd0, tbl[r].e_id});
      chk($sformatf("vec%0d_svc", r),   {31'd0, o_in_service}, {31'd0, tbl[r].e_svc});
      chk($sformatf("vec%0d_rdata", r), o_cfg_rdata,           tbl[r].e_rdata);
    end
    quiet(); t_rst = 0;

    // Edge-mode pulse, clear on grant, re-pend during service.
    do_reset();
    wr(2'd0, 32'h01);
    wr(2'd1, 32'h01);
    t_irq = 8'h01; cyc();
    t_irq = 8'h00; cyc(); cyc(); cyc();
    chk("edge_intr", {31'd0, o_intr}, 32'd1);
    chk("edge_id", {29'd0, o_irq_id}, 32'd0);
    t_addr = 2'd2; cyc();
    chk("edge_pend_set", o_cfg_rdata, 32'h01);
    t_inta = 1; cyc(); t_inta = 0;
    cyc();
    chk("edge_pend_clr", o_cfg_rdata, 32'h00);
    t_irq = 8'h01; cyc();
    t_irq = 8'h00; cyc(); cyc(); cyc();
    chk("edge_svc_no_intr", {31'd0, o_intr}, 32'd0);
    chk("edge_svc_hold", {31'd0, o_in_service}, 32'd1);
    cyc();
    chk("edge_repend", o_cfg_rdata, 32'h01);
    t_eoi = 1; cyc(); t_eoi = 0;
    chk("edge_eoi_idle", {31'd0, o_intr}, 32'd0);
    cyc();
    chk("edge_reraise", {31'd0, o_intr}, 32'd1);

    // Masked hold, then unmask.
    do_reset();
    t_irq = 8'h04;
    for (int n = 0; n < 20; n++) begin
      cyc();
      chk("masked_intr", {31'd0, o_intr}, 32'd0);
    end
    t_addr = 2'd2; cyc();
    chk("masked_pend", o_cfg_rdata, 32'h04);
    wr(2'd0, 32'h04);
    chk("unmask_same_edge", {31'd0, o_intr}, 32'd0);
    cyc();
    chk("unmask_intr", {31'd0, o_intr}, 32'd1);
    chk("unmask_id", {29'd0, o_irq_id}, 32'd2);

    // Sticky request survives masking and deassertion.
    do_reset();
    wr(2'd0, 32'hFF);
    t_irq = 8'h20;
    for (int n = 0; n < 10 && !o_intr; n++) cyc();
    chk("sticky_raise", {31'd0, o_intr}, 32'd1);
    chk("sticky_id", {29'd0, o_irq_id}, 32'd5);
    wr(2'd0, 32'h00);
    t_irq = 8'h00;
    cyc(); cyc(); cyc();
    chk("sticky_hold", {31'd0, o_intr}, 32'd1);
    chk("sticky_hold_id", {29'd0, o_irq_id}, 32'd5);
    t_inta = 1; cyc(); t_inta = 0;
    chk("sticky_svc", {31'd0, o_in_service}, 32'd1);
    chk("sticky_svc_id", {29'd0, o_irq_id}, 32'd5);
    chk("sticky_svc_intr", {31'd0, o_intr}, 32'd0);

    // Set-beats-clear collisions, plain W1C, reset during service.
    do_reset();
    wr(2'd0, 32'h02);
    wr(2'd1, 32'h02);
    t_irq = 8'h02; cyc();
    t_irq = 8'h00; cyc(); cyc(); cyc();
    chk("coll_req_id", {29'd0, o_irq_id}, 32'd1);
    chk("coll_req_intr", {31'd0, o_intr}, 32'd1);
    t_irq = 8'h02; cyc();
    t_irq = 8'h00; cyc();
    t_inta = 1; cyc(); t_inta = 0;
    t_addr = 2'd2; cyc();
    chk("coll_grant_edge", o_cfg_rdata, 32'h02);
    chk("coll_svc", {31'd0, o_in_service}, 32'd1);
    t_irq = 8'h02; cyc();
    t_irq = 8'h00; cyc();
    wr(2'd2, 32'h02);
    t_addr = 2'd2; cyc();
    chk("coll_w1c_edge", o_cfg_rdata, 32'h02);
    wr(2'd2, 32'h02);
    t_addr = 2'd2; cyc();
    chk("w1c_alone", o_cfg_rdata, 32'h00);
    t_rst = 1; cyc(); t_rst = 0;
    chk("rst_svc", {31'd0, o_in_service}, 32'd0);
    chk("rst_intr", {31'd0, o_intr}, 32'd0);
    chk("rst_id", {29'd0, o_irq_id}, 32'd0);
    t_addr = 2'd0; cyc();
    chk("rst_mask", o_cfg_rdata, 32'h0);
    t_addr = 2'd1; cyc();
    chk("rst_edge", o_cfg_rdata, 32'h0);
    t_addr = 2'd2; cyc();
    chk("rst_pend", o_cfg_rdata, 32'h0);

    // Randomized traffic against the model.
    do_reset();
    wr(2'd0, 32'hFF);
    wr(2'd1, 32'h0F);
    for (int n = 0; n < 3000; n++) begin
      t_rst  = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 3) == 0) t_irq = t_irq ^ (8'h01 << $urandom_range(0, 7));
      t_inta = ($urandom_range(0, 3) == 0);
      t_eoi  = ($urandom_range(0, 5) == 0);
      t_we   = ($urandom_range(0, 15) == 0);
      t_addr = 2'($urandom_range(0, 3));
      t_wdata = $urandom;
      cyc();
    end
    quiet(); t_rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
